count_ctrl: RTL

COUNT_CTRL -- requirements
Module: count_ctrl

---
 rtl/count_ctrl_pkg.sv | 17 +
 rtl/count_ctrl_if.sv | 32 +++
 rtl/count_core.sv | 27 ++
 rtl/count_ctrl.sv | 135 +++++++++++++
 4 files changed

// File: rtl/count_ctrl_pkg.sv
// count_ctrl_pkg -- shared definitions for the count_ctrl block.
//   state_t      : FSM state encoding (IDLE/RUN/PAUSE/DONE)
//   MODE_ONESHOT : mode value that stops in DONE at the terminal count
//   MODE_RELOAD  : mode value that wraps to zero at the terminal count
package count_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    DONE  = 2'b11
  } state_t;

  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_RELOAD  = 1'b1;

endpackage

// File: rtl/count_ctrl_if.sv
// count_ctrl_if -- request/status bundle between a controller and count_ctrl.
//   start, stop, clear : per-edge requests (priority clear > stop > start)
//   mode               : one-shot / auto-reload select
//   limit              : terminal count, BITS wide, sampled every edge
//   count              : current count, BITS wide
//   running            : high while the FSM is in RUN
//   done               : one-cycle terminal-count pulse
// Modports: master drives the requests, slave (the counter) drives status.
interface count_ctrl_if #(
  parameter int BITS = 4
);

  logic            start;
  logic            stop;
  logic            clear;
  logic            mode;
  logic [BITS-1:0] limit;
  logic [BITS-1:0] count;
  logic            running;
  logic            done;

  modport master (
    output start, stop, clear, mode, limit,
    input  count, running, done
  );

  modport slave (
    input  start, stop, clear, mode, limit,
    output count, running, done
  );

endinterface

// File: rtl/count_core.sv
// count_core -- BITS-wide up-counter, state changes on the falling clock edge.
//   clk       : clock (falling edge active)
//   rst_n     : asynchronous active-low reset, clears the count
//   en        : increment by one (modulo 2^BITS)
//   load_zero : synchronous load of zero, dominates en
//   count     : registered count value
module count_core #(
  parameter int BITS = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            load_zero,
  output logic [BITS-1:0] count
);

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load_zero) begin
      count <= '0;
    end else if (en) begin
      count <= count + BITS'(1);
    end
  end

endmodule

// File: rtl/count_ctrl.sv
// count_ctrl -- start/stop/pause counter controller with one-shot and
// auto-reload modes. All state updates on the falling edge of NEclk.
//   NEclk  : clock (falling edge active)
//   Nreset : asynchronous active-low reset
//   bus    : count_ctrl_if.slave (start, stop, clear, mode, limit in;
//            count, running, done out)
// Optional feature: define COUNT_CTRL_PRESCALE_EN to add parameter PRESCALE;
// a count tick then occurs only every PRESCALE edges spent in RUN.
module count_ctrl
  import count_ctrl_pkg::*;
#(
  parameter int BITS = 4
`ifdef COUNT_CTRL_PRESCALE_EN
  , parameter int PRESCALE = 4
`endif
) (
  input  logic        NEclk,
  input  logic        Nreset,
  count_ctrl_if.slave bus
);

  state_t          state;
  state_t          nxt;
  logic            running_q;
  logic            done_q;
  logic            done_n;
  logic            core_en;
  logic            core_zero;
  logic            tick;
  logic            start_ok;
  logic [BITS-1:0] cnt;

  // start only acts when stop is not requested on the same edge
  assign start_ok = bus.start && !bus.stop;

`ifdef COUNT_CTRL_PRESCALE_EN
  localparam int            PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pre;
  logic          pre_clr;
  logic          pre_adv;

  assign tick = (pre == PRE_LAST);

  // Prescaler restarts on clear and on a fresh run from IDLE or DONE;
  // it only advances on non-stop edges in RUN, so it holds across PAUSE.
  always_comb begin
    pre_clr = bus.clear || (start_ok && ((state == IDLE) || (state == DONE)));
    pre_adv = (state == RUN) && !bus.stop && !bus.clear;
  end

  always_ff @(negedge NEclk or negedge Nreset) begin
    if (!Nreset) begin
      pre <= '0;
    end else if (pre_clr) begin
      pre <= '0;
    end else if (pre_adv) begin
      pre <= tick ? '0 : pre + PW'(1);
    end
  end
`else
  assign tick = 1'b1;
`endif

  // Next-state and counter control for the coming edge
  always_comb begin
    nxt       = state;
    core_en   = 1'b0;
    core_zero = 1'b0;
    done_n    = 1'b0;
    if (bus.clear) begin
      nxt       = IDLE;
      core_zero = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          core_zero = 1'b1;
          if (start_ok) nxt = RUN;
        end
        RUN: begin
          // stop suppresses both the increment and the done pulse
          if (bus.stop) begin
            nxt = PAUSE;
          end else if (tick) begin
            if (cnt == bus.limit) begin
              done_n = 1'b1;
              if (bus.mode == MODE_RELOAD) core_zero = 1'b1;
              else                         nxt       = DONE;
            end else begin
              core_en = 1'b1;
            end
          end
        end
        PAUSE: begin
          if (start_ok) nxt = RUN;
        end
        DONE: begin
          if (start_ok) begin
            nxt       = RUN;
            core_zero = 1'b1;
          end
        end
        default: nxt = IDLE;
      endcase
    end
  end

  always_ff @(negedge NEclk or negedge Nreset) begin
    if (!Nreset) begin
      state     <= IDLE;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state     <= nxt;
      running_q <= (nxt == RUN);
      done_q    <= done_n;
    end
  end

  count_core #(
    .BITS (BITS)
  ) u_core (
    .clk       (NEclk),
    .rst_n     (Nreset),
    .en        (core_en),
    .load_zero (core_zero),
    .count     (cnt)
  );

  assign bus.count   = cnt;
  assign bus.running = running_q;
  assign bus.done    = done_q;

endmodule
